// File: rtl/last_beat_calc_bp_if.sv
// Beat-address tap, DMA-complete pulse and LAST-flag output handshake
// grouped for last_beat_calc_bp.
//   i_addr_data/i_addr_valid/i_addr_ready : beat address channel
//   i_dma_complete                        : one pulse per finished packet
//   o_prev_beat_last/_valid/_ready        : LAST flag for previous beat
interface last_beat_calc_bp_if #(
    parameter int unsigned ADDR_WIDTH = 12
) ();
    logic [ADDR_WIDTH-1:0] i_addr_data;
    logic                  i_addr_valid;
    logic                  i_addr_ready;
    logic                  i_dma_complete;
    logic                  o_prev_beat_last;
    logic                  o_prev_beat_last_valid;
    logic                  o_prev_beat_last_ready;

    // Driver side (address tap, PS and downstream FIFO)
    modport master (
        output i_addr_data, i_addr_valid, i_dma_complete, o_prev_beat_last_ready,
        input  i_addr_ready, o_prev_beat_last, o_prev_beat_last_valid
    );

    // Calculator side
    modport slave (
        input  i_addr_data, i_addr_valid, i_dma_complete, o_prev_beat_last_ready,
        output i_addr_ready, o_prev_beat_last, o_prev_beat_last_valid
    );
endinterface

// File: rtl/last_beat_calc_bp.sv
// Tags each accepted DMA beat's predecessor with a LAST flag.
// A beat whose masked address equals BASE_ADDR starts a new packet; a
// DMA-complete pulse ends the oldest outstanding packet.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   bus (slave)    : beat address channel, complete pulse, LAST output
//   o_outstanding  : packets started but not yet completed (registered)
//   o_err_spurious : sticky, a complete arrived with nothing to complete
module last_beat_calc_bp #(
    parameter int unsigned           ADDR_WIDTH = 12,
    parameter int unsigned           BUS_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_MASK  = '1,
    parameter int unsigned           CNT_W      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    last_beat_calc_bp_if.slave    bus,
    output logic [CNT_W:0]        o_outstanding,
    output logic                  o_err_spurious
);

    localparam int unsigned   CW      = CNT_W + 1;
    localparam logic [CW-1:0] MAX_OUT = CW'(2 ** CNT_W);

    // Bus width only documents the beat size; not used by the logic
    logic w_unused_bus_width;
    assign w_unused_bus_width = (BUS_WIDTH % 8) == 0;

    logic [CW-1:0] r_start_cnt;
    logic [CW-1:0] r_done_cnt;
    logic [CW-1:0] r_pend;
    logic [CW-1:0] r_outstanding;
    logic          r_valid;
    logic          r_last;
    logic          r_err;

    logic          w_slot_free;
    logic          w_addr_ready;
    logic          w_beat;
    logic          w_wrap;
    logic          w_arrive;
    logic          w_spurious;
    logic          w_proc;
    logic [CW-1:0] w_start_nxt;
    logic [CW-1:0] w_done_nxt;
    logic [CW-1:0] w_pend_nxt;
    logic          w_valid_nxt;
    logic          w_last_nxt;

    // Acceptance: output slot must be free and an outstanding slot available
    assign w_slot_free  = !r_valid || bus.o_prev_beat_last_ready;
    assign w_addr_ready = w_slot_free && (r_outstanding != MAX_OUT);
    assign w_beat       = bus.i_addr_valid && w_addr_ready;
    assign w_wrap       = ((bus.i_addr_data ^ BASE_ADDR) & ADDR_MASK) == '0;

    // A complete is only legal while some started packet lacks one
    assign w_arrive   = bus.i_dma_complete && (r_pend < r_outstanding);
    assign w_spurious = bus.i_dma_complete && !w_arrive;

    // Queued completes yield to beats; at most one output load per cycle
    assign w_proc = !w_beat && (r_pend != '0) && w_slot_free;

    // Next-state for counters and output register
    always_comb begin
        w_start_nxt = r_start_cnt;
        w_done_nxt  = r_done_cnt;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;

        if (w_beat) begin
            // With nothing outstanding there is no predecessor to tag
            if (r_outstanding != '0) begin
                w_valid_nxt = 1'b1;
                w_last_nxt  = w_wrap;
            end else begin
                w_valid_nxt = 1'b0;
            end
            if (w_wrap) begin
                w_start_nxt = r_start_cnt + CW'(1);
            end
        end else if (w_proc) begin
            w_done_nxt = r_done_cnt + CW'(1);
            // Only the last open packet still needs its final beat tagged;
            // otherwise a later start already released that LAST
            if (r_outstanding == CW'(1)) begin
                w_valid_nxt = 1'b1;
                w_last_nxt  = 1'b1;
            end else begin
                w_valid_nxt = 1'b0;
            end
        end else if (bus.o_prev_beat_last_ready) begin
            w_valid_nxt = 1'b0;
        end

        w_pend_nxt = r_pend + CW'(w_arrive) - CW'(w_proc);
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start_cnt   <= '0;
            r_done_cnt    <= '0;
            r_pend        <= '0;
            r_outstanding <= '0;
            r_valid       <= 1'b0;
            r_last        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_start_cnt   <= w_start_nxt;
            r_done_cnt    <= w_done_nxt;
            r_pend        <= w_pend_nxt;
            r_outstanding <= w_start_nxt - w_done_nxt;
            r_valid       <= w_valid_nxt;
            r_last        <= w_last_nxt;
            r_err         <= r_err | w_spurious;
        end
    end

    assign bus.i_addr_ready           = w_addr_ready;
    assign bus.o_prev_beat_last       = r_last;
    assign bus.o_prev_beat_last_valid = r_valid;
    assign o_outstanding              = r_outstanding;
    assign o_err_spurious             = r_err;

endmodule

// File: tb/tb_last_beat_calc_bp.sv
// Bench for last_beat_calc_bp: directed scenarios then random traffic,
// each cycle compared against a packet-level reference model.
module tb_last_beat_calc_bp;

    localparam int unsigned AW    = 12;
    localparam int unsigned CNT_W = 2;
    localparam int          MAXO  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [CNT_W:0]   outstanding;
    logic             err;

    always #5 clk = ~clk;

    last_beat_calc_bp_if #(.ADDR_WIDTH(AW)) bus ();

    last_beat_calc_bp #(
        .ADDR_WIDTH(AW),
        .BUS_WIDTH (32),
        .BASE_ADDR (12'h000),
        .ADDR_MASK (12'hFFF),
        .CNT_W     (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .o_outstanding (outstanding),
        .o_err_spurious(err)
    );

    // Reference model: unbounded packet counts and a queued-complete count
    int m_starts;
    int m_dones;
    int m_pend;
    bit m_valid;
    bit m_last;
    bit m_err;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_starts = 0;
        m_dones  = 0;
        m_pend   = 0;
        m_valid  = 1'b0;
        m_last   = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic drive_idle();
        bus.i_addr_valid           = 1'b0;
        bus.i_addr_data            = '0;
        bus.i_dma_complete         = 1'b0;
        bus.o_prev_beat_last_ready = 1'b1;
    endtask

    // One clock: check registered outputs, drive inputs, check ready, advance model
    task automatic step(input bit v, input logic [AW-1:0] a, input bit c, input bit r);
        int out;
        bit slot;
        bit ardy;
        bit beat;
        bit wrap;
        bit arrive;
        @(negedge clk);
        out = m_starts - m_dones;
        check("out_valid", 32'(bus.o_prev_beat_last_valid), 32'(m_valid));
        if (m_valid) check("out_last", 32'(bus.o_prev_beat_last), 32'(m_last));
        check("outstanding", 32'(outstanding), 32'(out));
        check("err_spurious", 32'(err), 32'(m_err));

        bus.i_addr_valid           = v;
        bus.i_addr_data            = a;
        bus.i_dma_complete         = c;
        bus.o_prev_beat_last_ready = r;
        #1;
        slot = !m_valid || r;
        ardy = slot && (out != MAXO);
        check("addr_ready", 32'(bus.i_addr_ready), 32'(ardy));

        beat   = v && ardy;
        wrap   = (a == '0);
        arrive = c && (m_pend < out);
        if (c && !arrive) m_err = 1'b1;
        if (beat) begin
            if (out > 0) begin
                m_valid = 1'b1;
                m_last  = wrap;
            end else begin
                m_valid = 1'b0;
            end
            if (wrap) m_starts++;
        end else if (m_pend > 0 && slot) begin
            m_pend--;
            m_dones++;
            if (out == 1) begin
                m_valid = 1'b1;
                m_last  = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end else if (r) begin
            m_valid = 1'b0;
        end
        if (arrive) m_pend++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic beat(input logic [AW-1:0] a);
        step(1'b1, a, 1'b0, 1'b1);
    endtask

    task automatic complete();
        step(1'b0, '0, 1'b1, 1'b1);
    endtask

    // Reset asserted between edges; outputs must clear without a clock
    task automatic async_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_valid", 32'(bus.o_prev_beat_last_valid), 32'd0);
        check("rst_last", 32'(bus.o_prev_beat_last), 32'd0);
        check("rst_outstanding", 32'(outstanding), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        drive_idle();
        model_reset();
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] ra;
        drive_idle();
        model_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("init_valid", 32'(bus.o_prev_beat_last_valid), 32'd0);
        check("init_outstanding", 32'(outstanding), 32'd0);
        reset = 1'b0;

        // Single 16 B packet, complete 5 cycles later
        beat(12'h000); beat(12'h004); beat(12'h008); beat(12'h00C);
        idle(4);
        complete();
        idle(4);

        // Back-to-back 8 B packets, two completes
        beat(12'h000); beat(12'h004); beat(12'h000); beat(12'h004);
        idle(1);
        complete();
        idle(2);
        complete();
        idle(3);

        // Saturation: fifth start blocked until a complete frees a slot
        for (int i = 0; i < 5; i++) beat(12'h000);
        step(1'b1, 12'h000, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) beat(12'h000);
        idle(2);
        for (int i = 0; i < 4; i++) begin
            complete();
            idle(1);
        end
        idle(3);

        // Complete coincident with an interior beat
        async_reset();
        beat(12'h000); beat(12'h004); beat(12'h000);
        step(1'b1, 12'h008, 1'b1, 1'b1);
        idle(3);

        // Output backpressure with a beat waiting
        beat(12'h00C);
        for (int i = 0; i < 3; i++) step(1'b1, 12'h010, 1'b0, 1'b0);
        step(1'b1, 12'h010, 1'b0, 1'b1);
        idle(2);
        complete(); idle(2); complete(); idle(3);

        // Spurious complete, then reset mid-packet
        complete();
        idle(2);
        beat(12'h000); beat(12'h004);
        async_reset();
        beat(12'h000);
        idle(2);

        // Random traffic with one reset in the middle
        for (int n = 0; n < 800; n++) begin
            if (n == 400) async_reset();
            ra = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(1, 4095));
            step(($urandom_range(0, 9) < 7), ra,
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0));
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
